// File: rtl/inst_encoder_pkg.sv
// Shared constants for the MIPS instruction encoder: format codes, instruction field bit ranges,
// FSM state type and the field-packing function.
package inst_encoder_pkg;

    localparam int unsigned W_FMT = 2;

    localparam logic [W_FMT-1:0] FMT_R = 2'd0;
    localparam logic [W_FMT-1:0] FMT_I = 2'd1;
    localparam logic [W_FMT-1:0] FMT_J = 2'd2;
    localparam logic [W_FMT-1:0] FMT_X = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    // Field bit ranges shared with the decoder so the two can never disagree.
    localparam int unsigned FLD_OP_HI    = 31;
    localparam int unsigned FLD_OP_LO    = 26;
    localparam int unsigned FLD_RS_HI    = 25;
    localparam int unsigned FLD_RS_LO    = 21;
    localparam int unsigned FLD_RT_HI    = 20;
    localparam int unsigned FLD_RT_LO    = 16;
    localparam int unsigned FLD_RD_HI    = 15;
    localparam int unsigned FLD_RD_LO    = 11;
    localparam int unsigned FLD_SHA_HI   = 10;
    localparam int unsigned FLD_SHA_LO   = 6;
    localparam int unsigned FLD_FUNCT_HI = 5;
    localparam int unsigned FLD_FUNCT_LO = 0;
    localparam int unsigned FLD_IMM_HI   = 15;
    localparam int unsigned FLD_IMM_LO   = 0;
    localparam int unsigned FLD_ADDR_HI  = 25;
    localparam int unsigned FLD_ADDR_LO  = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFull = 2'd2
    } enc_state_e;

    function automatic logic [31:0] encode_fields(
        input logic [W_FMT-1:0] fmt,
        input logic [5:0]       op,
        input logic [5:0]       funct,
        input logic [4:0]       rs,
        input logic [4:0]       rt,
        input logic [4:0]       rd,
        input logic [4:0]       sha,
        input logic [15:0]      imm,
        input logic [25:0]      addr
    );
        logic [31:0] w;
        w = '0;
        case (fmt)
            FMT_R: begin
                // R-type opcode is always zero; in_op is deliberately ignored.
                w[FLD_OP_HI:FLD_OP_LO]       = OP_RTYPE;
                w[FLD_RS_HI:FLD_RS_LO]       = rs;
                w[FLD_RT_HI:FLD_RT_LO]       = rt;
                w[FLD_RD_HI:FLD_RD_LO]       = rd;
                w[FLD_SHA_HI:FLD_SHA_LO]     = sha;
                w[FLD_FUNCT_HI:FLD_FUNCT_LO] = funct;
            end
            FMT_I: begin
                w[FLD_OP_HI:FLD_OP_LO]   = op;
                w[FLD_RS_HI:FLD_RS_LO]   = rs;
                w[FLD_RT_HI:FLD_RT_LO]   = rt;
                w[FLD_IMM_HI:FLD_IMM_LO] = imm;
            end
            FMT_J: begin
                w[FLD_OP_HI:FLD_OP_LO]     = op;
                w[FLD_ADDR_HI:FLD_ADDR_LO] = addr;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-level input stream and encoded-word output stream of the instruction encoder.
interface inst_encoder_if #(
    parameter int unsigned W_CPU = 32,
    parameter int unsigned AW    = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_fmt;
    logic [5:0]       in_op;
    logic [5:0]       in_funct;
    logic [4:0]       in_rs;
    logic [4:0]       in_rt;
    logic [4:0]       in_rd;
    logic [4:0]       in_sha;
    logic [15:0]      in_imm;
    logic [25:0]      in_addr;
    logic             out_valid;
    logic             out_ready;
    logic [W_CPU-1:0] out_inst;
    logic [AW-1:0]    out_waddr;

    modport slave (
        input  in_valid, in_fmt, in_op, in_funct, in_rs, in_rt, in_rd, in_sha, in_imm, in_addr,
        input  out_ready,
        output in_ready, out_valid, out_inst, out_waddr
    );

    modport master (
        output in_valid, in_fmt, in_op, in_funct, in_rs, in_rt, in_rd, in_sha, in_imm, in_addr,
        output out_ready,
        input  in_ready, out_valid, out_inst, out_waddr
    );
endinterface

// File: rtl/inst_enc_fifo2.sv
// Two-entry valid/ready buffer with synchronous flush; flush wins over push and pop.
module inst_enc_fifo2 #(
    parameter int unsigned Width = 42
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic             valid,
    output logic             space,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] mem_d [2];
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic [1:0]       cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = 1'b0;
            rd_d  = 1'b0;
            cnt_d = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_q] = wdata;
                wr_d        = ~wr_q;
            end
            if (pop) begin
                rd_d = ~rd_q;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
        end
    end

    assign valid = (cnt_q != 2'd0);
    assign space = (cnt_q != 2'd2);
    assign rdata = mem_q[rd_q];

endmodule

// File: rtl/inst_encoder.sv
// Streaming MIPS instruction encoder: packs field descriptions into instruction words and tags
// them with sequential instruction-memory addresses for the program loader.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int unsigned W_CPU = 32,
    parameter int unsigned AW    = 10,
    parameter int unsigned DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    inst_encoder_if.slave bus,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err_fmt
);

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    enc_state_e    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;

    logic                  accept;
    logic                  fifo_pop;
    logic                  fifo_valid;
    logic                  fifo_space;
    logic [W_CPU-1:0]      inst_word;
    logic [W_CPU+AW-1:0]   fifo_wdata;
    logic [W_CPU+AW-1:0]   fifo_rdata;

    assign bus.in_ready = (state_q == StRun) && !start && fifo_space;
    assign accept       = bus.in_valid && bus.in_ready;
    assign fifo_pop     = fifo_valid && bus.out_ready;

    assign inst_word  = W_CPU'(encode_fields(bus.in_fmt, bus.in_op, bus.in_funct, bus.in_rs,
                                             bus.in_rt, bus.in_rd, bus.in_sha, bus.in_imm,
                                             bus.in_addr));
    assign fifo_wdata = {inst_word, ptr_q};

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        if (start) begin
            state_d = StRun;
            // An out-of-range base still allows exactly one beat at the last address.
            ptr_d   = (base_addr > LastAddr) ? LastAddr : base_addr;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            if (fifo_pop) begin
                count_d = count_q + (AW + 1)'(1);
            end
            if (accept) begin
                if (bus.in_fmt == FMT_X) begin
                    err_d = 1'b1;
                end
                if (ptr_q == LastAddr) begin
                    state_d = StFull;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    inst_enc_fifo2 #(
        .Width (W_CPU + AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start),
        .push  (accept),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .valid (fifo_valid),
        .space (fifo_space),
        .rdata (fifo_rdata)
    );

    assign bus.out_valid                 = fifo_valid;
    assign {bus.out_inst, bus.out_waddr} = fifo_rdata;

    assign count   = count_q;
    assign full    = (state_q == StFull);
    assign err_fmt = err_q;

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streaming MIPS instruction encoder: the inverse of the decode stage.
- Accepts field-level instruction descriptions (format, opcode, funct, rs, rt, rd, shamt, imm, jump addr) over a valid/ready handshake.
- Packs each into a 32-bit instruction word and emits it with a sequential instruction-memory word address.
- Used by the test/program-loader path to fill instruction memory before the CPU runs.

Parameters:
- W_CPU, 32, instruction word width.
- AW, 10, instruction-memory word-address width.
- DEPTH, 1024, number of instruction-memory words; last valid address is DEPTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: load base_addr, clear count/err, flush buffer, enter RUN.
- base_addr  in  AW  first word address used after start.
- in_valid  in  1  input beat valid.
- in_ready  out  1  encoder can accept a beat.
- in_fmt  in  2  0=R, 1=I, 2=J, 3=illegal.
- in_op  in  6  opcode (I/J formats).
- in_funct  in  6  funct (R format).
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_sha  in  5  shift amount.
- in_imm  in  16  immediate.
- in_addr  in  26  jump target field.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer (imem write port) accepts the word.
- out_inst  out  W_CPU  encoded instruction.
- out_waddr  out  AW  word address for out_inst.
- count  out  AW+1  words delivered since last start.
- full  out  1  last address consumed; no further input accepted.
- err_fmt  out  1  sticky: an illegal format was seen since start.

Behaviour:
- Reset (async, immediate) clears everything:
  - state=IDLE; in_ready=0; out_valid=0; out_inst=0; out_waddr=0; count=0; full=0; err_fmt=0; buffer empty; write pointer=0.
- States:
  - IDLE: in_ready=0; start -> RUN.
  - RUN: accepts beats; an accept at pointer==DEPTH-1 -> FULL.
  - FULL: in_ready=0, full=1; buffer drains normally; start -> RUN.
  - start from any state -> RUN.
- in_ready = (state==RUN) & ~start & (buffer has a free entry); combinational.
- Encoding, performed at accept:
  - R: {6'b0, rs, rt, rd, sha, funct}. in_op is ignored and the opcode is forced to 0.
  - I: {op, rs, rt, imm}.
  - J: {op, addr}.
  - Illegal (fmt 3): word = 32'h0 (NOP), err_fmt set to 1 the next cycle.
- Address: the beat is tagged with the current write pointer, and the pointer increments on accept.
  - Pointer never wraps; FULL prevents any accept past DEPTH-1.
- Buffer: 2-entry FIFO of {inst, waddr}.
  - Latency: a beat accepted in cycle N gives out_valid=1 in N+1.
  - Throughput is 1/cycle while out_ready=1.
  - Order is preserved.
  - Simultaneous push and pop with one entry: occupancy stays 1.
- Output handshake: out_inst/out_waddr stay stable while out_valid=1 and out_ready=0. count increments on each out_valid&out_ready.
- start takes priority over a simultaneous in_valid (the beat is not accepted) and over a pop.
  - Buffer flushes: out_valid=0 in the next cycle.
  - Pointer=base_addr, count=0, err_fmt=0, full=0.
- base_addr > DEPTH-1 at start: pointer saturates to DEPTH-1, so exactly one beat is accepted, then FULL.
- count width AW+1 covers DEPTH; no overflow.

Decomposition:
- Add FMT_R/FMT_I/FMT_J/FMT_X constants and W_FMT=2 to lib/opcodes.v alongside the existing OP_*/F_* and FLD_* field definitions.
- Field packing reuses the FLD_* bit ranges so encoder and decoder cannot diverge.
- One sub-module: inst_enc_fifo2, the 2-entry valid/ready buffer (clk, rst, flush, push/pop, data width W_CPU+AW).

Test Plan:
- rst, start base_addr=0; R add: rs=8, rt=9, rd=10, sha=0, funct=0x20 -> next cycle out_inst=0x01095020, out_waddr=0; after handshake count=1.
- I addi: op=0x08, rs=0, rt=8, imm=0x0005 -> 0x20080005 at waddr 0. Then J: op=0x02, addr=0x0100000 -> 0x08100000 at waddr 1.
- out_ready=0 with 3 beats offered -> two accepted, in_ready=0, out_inst held. Release -> words delivered in order at waddr 0,1,2; count=3.
- DEPTH=4, start base_addr=2 -> beats accepted at waddr 2,3, then full=1, in_ready=0. Buffer drains. start base_addr=0 -> full=0, in_ready=1.
- in_fmt=3 -> out_inst=0x00000000 and err_fmt=1 until the next start. Also: start asserted with in_valid=1 -> beat not accepted, buffer flushed.
- Assert rst mid-stream with 2 entries buffered -> out_valid, in_ready, count, full drop to 0 without waiting for a clk edge.
